// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle RISC-V control unit.
// Holds opcode and funct3 constants plus the FSM state, ALU operation,
// immediate-type and datapath mux-select enumerations.
package mc_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_t;
    typedef enum logic [1:0] {A_PC, A_OLDPC, A_RD1, A_ZERO} src_a_t;
    typedef enum logic [1:0] {B_RD2, B_IMM, B_FOUR} src_b_t;
    typedef enum logic [1:0] {R_ALU, R_MEM, R_ALUOUT} res_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational funct3/func7_bit5/opcode -> ALU operation.
// Ports: opcode, funct3, func7_bit5 in; alu_control (ALUCTRL_W bits) out.
module alu_decoder
    import mc_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 func7_bit5,
    output logic [ALUCTRL_W-1:0] alu_control
);
    alu_op_t op;

    always_comb begin
        op = ALU_ADD;
        case (funct3)
            F3_ADD:  op = (opcode == OP_R && func7_bit5) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = func7_bit5 ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
        endcase
    end

    assign alu_control = ALUCTRL_W'(op);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FSM controller for a multicycle RISC-V datapath.
// Inputs: clk, reset (sync, active-high), opcode, funct3, func7_bit5,
//   zero/lt/ltu branch flags, mem_ready handshake.
// Outputs: pcwrite, adrsource, memwrite, irwrite, regwrite strobes,
//   imm_source, alu_source_a/b, alu_control, resultsource mux selects,
//   sticky illegal trap flag and state_o for debug.
// Optional feature macro BRANCH_EXT_EN adds blt/bge/bltu/bgeu; without it
// those branches trap in DECODE.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int ALUCTRL_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 func7_bit5,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic                 pcwrite,
    output logic                 adrsource,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regwrite,
    output logic [2:0]           imm_source,
    output logic [1:0]           alu_source_a,
    output logic [1:0]           alu_source_b,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           resultsource,
    output logic                 illegal,
    output logic [3:0]           state_o
);
    state_t state, state_n;
    logic [7:0] cnt;
    logic illegal_q, taken, branch_ok, timeout, waiting, use_dec;
    logic pcw, adr, mw, irw, rw;
    imm_t imm;
    src_a_t sa;
    src_b_t sb;
    alu_op_t aop;
    res_t rs;
    logic [ALUCTRL_W-1:0] dec_ctrl;

    alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_dec (
        .opcode(opcode), .funct3(funct3), .func7_bit5(func7_bit5), .alu_control(dec_ctrl)
    );

`ifdef BRANCH_EXT_EN
    // funct3[0] inverts the base condition (bne, bge, bgeu)
    assign taken = (funct3[2] ? (funct3[1] ? ltu : lt) : zero) ^ funct3[0];
    assign branch_ok = funct3[2:1] != 2'b01;
`else
    logic unused_cmp;
    assign unused_cmp = &{1'b0, lt, ltu};
    assign taken = zero ^ funct3[0];
    assign branch_ok = funct3[2:1] == 2'b00;
`endif

    // Counter holds the number of stall cycles already spent in this wait state.
    assign waiting = state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE;
    assign timeout = !mem_ready && cnt == 8'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RESET;
            cnt       <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= (waiting && !mem_ready) ? cnt + 8'd1 : '0;
            illegal_q <= illegal_q | (state_n == S_TRAP);
        end
    end

    always_comb begin
        state_n = state;
        pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0;
        imm = IMM_I; sa = A_PC; sb = B_RD2; aop = ALU_ADD; use_dec = 1'b0; rs = R_ALU;
        case (state)
            S_RESET: state_n = S_FETCH;
            S_FETCH: begin
                sb = B_FOUR;
                irw = mem_ready;
                pcw = mem_ready;
                state_n = mem_ready ? S_DECODE : (timeout ? S_TRAP : S_FETCH);
            end
            S_DECODE: begin
                sa = A_OLDPC;
                sb = B_IMM;
                imm = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_R:              state_n = S_EXEC_R;
                    OP_I:              state_n = S_EXEC_I;
                    OP_BRANCH:         state_n = branch_ok ? S_BRANCH : S_TRAP;
                    OP_JAL:            state_n = S_JAL;
                    OP_JALR:           state_n = S_JALR;
                    OP_LUI, OP_AUIPC:  state_n = S_LUI;
                    default:           state_n = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                sa = A_RD1;
                sb = B_IMM;
                imm = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_n = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                rs = R_ALUOUT;
                adr = 1'b1;
                state_n = mem_ready ? S_MEMWB : (timeout ? S_TRAP : S_MEMREAD);
            end
            S_MEMWRITE: begin
                rs = R_ALUOUT;
                adr = 1'b1;
                mw = 1'b1;
                state_n = mem_ready ? S_FETCH : (timeout ? S_TRAP : S_MEMWRITE);
            end
            S_MEMWB: begin
                rs = R_MEM;
                rw = 1'b1;
                state_n = S_FETCH;
            end
            S_EXEC_R: begin
                sa = A_RD1;
                use_dec = 1'b1;
                state_n = S_ALUWB;
            end
            S_EXEC_I: begin
                sa = A_RD1;
                sb = B_IMM;
                use_dec = 1'b1;
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                rs = R_ALUOUT;
                rw = 1'b1;
                state_n = S_FETCH;
            end
            S_BRANCH: begin
                sa = A_RD1;
                aop = ALU_SUB;
                rs = R_ALUOUT;
                pcw = taken;
                state_n = S_FETCH;
            end
            S_JAL: begin
                sa = A_OLDPC;
                sb = B_FOUR;
                imm = IMM_J;
                rs = R_ALUOUT;
                pcw = 1'b1;
                rw = 1'b1;
                state_n = S_FETCH;
            end
            S_JALR: begin
                sa = A_RD1;
                sb = B_IMM;
                pcw = 1'b1;
                state_n = S_FETCH;
            end
            S_LUI: begin
                imm = IMM_U;
                sa = (opcode == OP_LUI) ? A_ZERO : A_OLDPC;
                sb = B_IMM;
                state_n = S_ALUWB;
            end
            S_TRAP: state_n = S_TRAP;
            default: state_n = S_RESET;
        endcase
    end

    // Every output is forced low while reset is asserted so an aborted access
    // cannot issue a write strobe in the reset cycle.
    assign pcwrite      = pcw & !reset;
    assign adrsource    = adr & !reset;
    assign memwrite     = mw & !reset;
    assign irwrite      = irw & !reset;
    assign regwrite     = rw & !reset;
    assign imm_source   = reset ? 3'b000 : imm;
    assign alu_source_a = reset ? 2'b00 : sa;
    assign alu_source_b = reset ? 2'b00 : sb;
    assign alu_control  = reset ? '0 : (use_dec ? dec_ctrl : ALUCTRL_W'(aop));
    assign resultsource = reset ? 2'b00 : rs;
    assign illegal      = illegal_q & !reset;
    assign state_o      = reset ? 4'd0 : state;
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready before trap, range 1..255.
REQ-002 Parameter ALUCTRL_W, default 4: alu_control width, minimum 4.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge), then reset input 1.
REQ-004 Ports SHALL be:
- opcode input 7: current instruction opcode.
- funct3 input 3: current instruction funct3.
- func7_bit5 input 1: instr[30].
- zero input 1: ALU result == 0.
- lt input 1: signed rs1<rs2.
- ltu input 1: unsigned rs1<rs2.
- mem_ready input 1: memory access completes this cycle.
- pcwrite, adrsource, memwrite, irwrite, regwrite output 1 each: datapath strobes.
- imm_source output 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- alu_source_a output 2: 00 PC, 01 OLDPC, 10 RD1, 11 zero.
- alu_source_b output 2: 00 RD2, 01 IMMEXT, 10 constant 4.
- alu_control output ALUCTRL_W: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9.
- resultsource output 2: 00 ALU result, 01 memory data, 10 ALUOut register.
- illegal output 1: sticky trap flag.
- state_o output 4: current state for debug.

Function
REQ-005 States SHALL be RESET, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, LUI, TRAP.
REQ-006 RESET SHALL drive all strobes to 0 and go to FETCH next cycle.
REQ-007 FETCH: adrsource=0, a=PC, b=4, ADD; hold while mem_ready=0; on mem_ready=1 assert irwrite=1 and pcwrite=1 with resultsource=00 in that same cycle, then go to DECODE.
REQ-008 DECODE: a=OLDPC, b=IMMEXT, imm_source=B, ADD (branch target into ALUOut). Next state by opcode: load/store->MEMADR, 0110011->EXEC_R, 0010011->EXEC_I, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111/0010111->LUI; any other->TRAP.
REQ-009 MEMADR: a=RD1, b=IMMEXT, imm_source I for load and S for store, ADD; next MEMREAD (load) or MEMWRITE (store).
REQ-010 MEMREAD and MEMWRITE: resultsource=10, adrsource=1; memwrite=1 for every MEMWRITE cycle. Wait on mem_ready; then go MEMREAD->MEMWB or MEMWRITE->FETCH.
REQ-011 MEMWB: resultsource=01, regwrite=1; next FETCH.
REQ-012 EXEC_R/EXEC_I: a=RD1, b=RD2 (R) or IMMEXT (I). ALU op from funct3: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND. SUB is selected only when R-type and func7_bit5=1. SRA is selected when func7_bit5=1 (R or I). Next ALUWB.
REQ-013 ALUWB: resultsource=10, regwrite=1; next FETCH.
REQ-014 BRANCH: a=RD1, b=RD2, SUB, resultsource=10. pcwrite=taken, where beq=zero, bne=!zero; blt/bge/bltu/bgeu per REQ-022. Next FETCH.
REQ-015 JAL: a=OLDPC, b=4, ADD, resultsource=10, pcwrite=1 (target computed in DECODE with imm J), regwrite=1 for link; next FETCH. JAL SHALL re-select imm J in DECODE.
REQ-016 JALR: a=RD1, b=IMMEXT, imm I, ADD, resultsource=00, pcwrite=1; next ALUWB is not used, link written via JAL-style extra state folded in -- next FETCH.
REQ-017 LUI: imm U, a=zero (LUI) or OLDPC (AUIPC), b=IMMEXT, ADD; next ALUWB.
REQ-018 Wait counter SHALL reset to 0 on entry to FETCH/MEMREAD/MEMWRITE and increment per stalled cycle. When it reaches MEM_TIMEOUT with mem_ready=0, the FSM SHALL go to TRAP.
REQ-019 TRAP SHALL set illegal=1, hold all strobes 0, and remain until reset.
REQ-020 When mem_ready=1 on the same cycle the counter hits MEM_TIMEOUT, completion SHALL win.

Reset
REQ-021 reset=1 sampled at a clk edge SHALL force RESET, clear the counter and illegal, and abort any in-flight access with no memwrite/regwrite/pcwrite in the following cycle; all outputs are 0 during reset.

Configuration
REQ-022 With BRANCH_EXT_EN defined, blt=lt, bge=!lt, bltu=ltu, bgeu=!ltu. Without it, funct3 100-111 on a branch SHALL go to TRAP from DECODE, and funct3 010/011 always go to TRAP.

Structure
REQ-023 Package mc_pkg SHALL hold opcode, state, ALU-op, imm/source select encodings and funct3 constants.
REQ-024 Sub-module alu_decoder (combinational funct3/func7_bit5/opcode -> alu_control) is instantiated once.

Verification
REQ-025 add x3,x1,x2 with mem_ready=1 -> FETCH,DECODE,EXEC_R,ALUWB; alu_control=1 when func7_bit5=1, else 0; regwrite=1 in cycle 4.
REQ-026 lw with mem_ready low for 3 cycles in MEMREAD -> adrsource=1 for 4 cycles, then MEMWB with resultsource=01.
REQ-027 MEM_TIMEOUT=15, mem_ready stuck 0 in FETCH -> TRAP after 15 stall cycles, illegal=1 until reset.
REQ-028 beq with zero=0 -> pcwrite=0 in BRANCH; bne with zero=0 -> pcwrite=1.
REQ-029 blt with lt=1 -> pcwrite=1 with BRANCH_EXT_EN defined, TRAP without it.
REQ-030 reset asserted during MEMWRITE -> next cycle state_o=RESET, memwrite=0.
